// File: rtl/ifu_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and helpers for the instruction-fetch sequencer.
//   fetch_state_e : sequencer states (IDLE / RUN / DRAIN)
//   FETCH_BYTES   : size of one aligned fetch group in bytes
//   INST_BYTES    : size of one instruction in bytes
//   fetch_size()  : instructions left in the current fetch group for a PC
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam int unsigned FETCH_BYTES = 16;
  localparam int unsigned INST_BYTES  = 4;

  // Number of instructions from pc up to the next fetch-group boundary (1..4).
  function automatic logic [2:0] fetch_size(input logic [31:0] pc);
    fetch_size = 3'((FETCH_BYTES - (pc % FETCH_BYTES)) / INST_BYTES);
  endfunction

endpackage

// File: rtl/fetch_credit_ctr.sv
// -----------------------------------------------------------------------------
// fetch_credit_ctr
// Tracks outstanding I-cache requests and derives the issue credit.
// Ports:
//   clock, reset      : clock and synchronous active-low reset
//   i_inc             : a request fired this cycle
//   i_dec             : a response (kept or dropped) arrived this cycle
//   i_buf_count       : instruction-buffer occupancy in groups
//   o_inflight        : current outstanding count
//   o_inflight_nxt    : outstanding count after this cycle's updates
//   o_free            : IBUF_DEPTH - buf_count - inflight, 5-bit signed
//   o_can_issue       : free > 0 and inflight below MAX_INFLIGHT
// -----------------------------------------------------------------------------
module fetch_credit_ctr #(
  parameter int IBUF_DEPTH   = 6,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_inc,
  input  logic              i_dec,
  input  logic [3:0]        i_buf_count,
  output logic [2:0]        o_inflight,
  output logic [2:0]        o_inflight_nxt,
  output logic signed [4:0] o_free,
  output logic              o_can_issue
);

  localparam logic [4:0] DEPTH_5   = 5'(IBUF_DEPTH);
  localparam logic [2:0] MAX_INF_3 = 3'(MAX_INFLIGHT);

  logic [2:0]        r_inflight;
  logic [2:0]        w_inflight_nxt;
  logic signed [4:0] w_free;

  // Next outstanding count; a fire and a response in the same cycle cancel.
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (i_inc && !i_dec) begin
      w_inflight_nxt = r_inflight + 3'd1;
    end else if (!i_inc && i_dec && (r_inflight != 3'd0)) begin
      // Underflow is a protocol error caught by the checker; hold at zero.
      w_inflight_nxt = r_inflight - 3'd1;
    end else begin
      w_inflight_nxt = r_inflight;
    end
  end

  // Outstanding-request counter register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_inflight <= 3'd0;
    end else begin
      r_inflight <= w_inflight_nxt;
    end
  end

  // Credit: the buffer must have room for everything already requested.
  always_comb begin
    w_free      = DEPTH_5 - {1'b0, i_buf_count} - {2'b00, r_inflight};
    o_can_issue = (w_free > 5'sd0) && (r_inflight < MAX_INF_3);
  end

  assign o_inflight     = r_inflight;
  assign o_inflight_nxt = w_inflight_nxt;
  assign o_free         = w_free;

endmodule

// File: rtl/ifu_fetch_ctrl_chk.sv
// -----------------------------------------------------------------------------
// ifu_fetch_ctrl_chk
// Protocol checker for the fetch sequencer (simulation only content).
// Ports:
//   clock, reset    : clock and synchronous active-low reset
//   i_enq_valid     : enqueue into the instruction buffer
//   i_buf_count     : buffer occupancy
//   i_resp_valid    : I-cache response
//   i_inflight      : outstanding request count
// -----------------------------------------------------------------------------
module ifu_fetch_ctrl_chk #(
  parameter int IBUF_DEPTH = 6
) (
  input logic       clock,
  input logic       reset,
  input logic       i_enq_valid,
  input logic [3:0] i_buf_count,
  input logic       i_resp_valid,
  input logic [2:0] i_inflight
);

  localparam logic [4:0] DEPTH_5 = 5'(IBUF_DEPTH);

  // Buffer overflow and unsolicited responses are never legal outside reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      assert (!(i_enq_valid && ({1'b0, i_buf_count} >= DEPTH_5)))
        else $error("ifu_fetch_ctrl: enqueue while instruction buffer full");
      assert (!(i_resp_valid && (i_inflight == 3'd0)))
        else $error("ifu_fetch_ctrl: response with no request outstanding");
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// ifu_fetch_ctrl
// Fetch sequencer: issues 16-byte-aligned I-cache requests under a credit
// limit, forwards responses to the instruction buffer, and on a redirect
// flushes the buffer and discards stale responses before resuming.
// Ports:
//   clock, reset                        : clock, synchronous active-low reset
//   io_redirect_valid/target            : redirect request and new PC
//   io_req_valid/ready/bits_pc/bits_size: I-cache request channel
//   io_resp_valid/ready                 : I-cache response channel
//   io_buf_enq_valid, io_buf_count      : instruction-buffer enqueue / level
//   io_flush                            : instruction-buffer flush
//   io_inflight                         : outstanding request count (debug)
// Optional build macro IFU_FETCH_PERF_EN adds saturating counters
//   io_perf_stall (RUN cycles without credit) and io_perf_drop (dropped
//   responses).
// -----------------------------------------------------------------------------
module ifu_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          IBUF_DEPTH   = 6,
  parameter int          MAX_INFLIGHT = 2,
  parameter logic [31:0] RESET_PC     = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_redirect_valid,
  input  logic [31:0] io_redirect_target,
  output logic        io_req_valid,
  input  logic        io_req_ready,
  output logic [31:0] io_req_bits_pc,
  output logic [2:0]  io_req_bits_size,
  input  logic        io_resp_valid,
  output logic        io_resp_ready,
  output logic        io_buf_enq_valid,
  input  logic [3:0]  io_buf_count,
  output logic        io_flush,
  output logic [2:0]  io_inflight
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [31:0] io_perf_stall,
  output logic [31:0] io_perf_drop
`endif
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [31:0]       r_pc;
  logic [2:0]        w_inflight;
  logic [2:0]        w_inflight_nxt;
  logic signed [4:0] w_free;
  logic              w_can_issue;
  logic              w_run;
  logic              w_redirect;
  logic              w_req_fire;
  logic              w_drop;

  fetch_credit_ctr #(
    .IBUF_DEPTH   (IBUF_DEPTH),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_credit (
    .clock          (clock),
    .reset          (reset),
    .i_inc          (w_req_fire),
    .i_dec          (io_resp_valid),
    .i_buf_count    (io_buf_count),
    .o_inflight     (w_inflight),
    .o_inflight_nxt (w_inflight_nxt),
    .o_free         (w_free),
    .o_can_issue    (w_can_issue)
  );

  // Handshake and flush decode from the current state.
  always_comb begin
    w_run            = (r_state == ST_RUN);
    // Redirects are ignored while IDLE.
    w_redirect       = io_redirect_valid && (r_state != ST_IDLE);
    io_req_valid     = w_run && w_can_issue && !io_redirect_valid;
    w_req_fire       = io_req_valid && io_req_ready;
    io_buf_enq_valid = w_run && !io_redirect_valid && io_resp_valid;
    io_flush         = w_redirect;
    w_drop           = io_resp_valid &&
                       ((r_state == ST_DRAIN) || (w_run && io_redirect_valid));
    io_resp_ready    = 1'b1;
    io_req_bits_pc   = r_pc;
    io_req_bits_size = fetch_size(r_pc);
    io_inflight      = w_inflight;
  end

  // Next-state logic; leaving DRAIN waits for the last stale response.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (io_redirect_valid) begin
          w_state_nxt = (w_inflight_nxt == 3'd0) ? ST_RUN : ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = (w_inflight_nxt == 3'd0) ? ST_RUN : ST_DRAIN;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch PC: redirect target wins, otherwise advance to the next group.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= io_redirect_target & ~32'd3;
    end else if (w_req_fire) begin
      r_pc <= {r_pc[31:4] + 28'd1, 4'h0};
    end else begin
      r_pc <= r_pc;
    end
  end

`ifdef IFU_FETCH_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_drop;

  // Saturating performance counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_perf_stall <= 32'd0;
      r_perf_drop  <= 32'd0;
    end else begin
      if (w_run && (w_free <= 5'sd0) && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end else begin
        r_perf_stall <= r_perf_stall;
      end
      if (w_drop && (r_perf_drop != 32'hFFFF_FFFF)) begin
        r_perf_drop <= r_perf_drop + 32'd1;
      end else begin
        r_perf_drop <= r_perf_drop;
      end
    end
  end

  assign io_perf_stall = r_perf_stall;
  assign io_perf_drop  = r_perf_drop;
`else
  logic w_drop_unused;
  assign w_drop_unused = w_drop;
`endif

  ifu_fetch_ctrl_chk #(
    .IBUF_DEPTH (IBUF_DEPTH)
  ) u_chk (
    .clock        (clock),
    .reset        (reset),
    .i_enq_valid  (io_buf_enq_valid),
    .i_buf_count  (io_buf_count),
    .i_resp_valid (io_resp_valid),
    .i_inflight   (w_inflight)
  );

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ifu_fetch_ctrl
// Directed bench for ifu_fetch_ctrl. Inputs change 1 time unit after each
// rising edge; outputs are sampled 1 unit later, well away from the edge.
// -----------------------------------------------------------------------------
module tb_ifu_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic [2:0]  req_size;
  logic        resp_valid;
  logic        resp_ready;
  logic        enq_valid;
  logic [3:0]  buf_count;
  logic        flush;
  logic [2:0]  inflight;
`ifdef IFU_FETCH_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_drop;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ifu_fetch_ctrl dut (
    .clock              (clock),
    .reset              (reset),
    .io_redirect_valid  (redir_valid),
    .io_redirect_target (redir_target),
    .io_req_valid       (req_valid),
    .io_req_ready       (req_ready),
    .io_req_bits_pc     (req_pc),
    .io_req_bits_size   (req_size),
    .io_resp_valid      (resp_valid),
    .io_resp_ready      (resp_ready),
    .io_buf_enq_valid   (enq_valid),
    .io_buf_count       (buf_count),
    .io_flush           (flush),
    .io_inflight        (inflight)
`ifdef IFU_FETCH_PERF_EN
    ,
    .io_perf_stall      (perf_stall),
    .io_perf_drop       (perf_drop)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; redir_valid = 1'b0; redir_target = 32'd0;
    req_ready = 1'b0; resp_valid = 1'b0; buf_count = 4'd0;
    repeat (3) tick;
    #1;
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_enq_valid", {31'd0, enq_valid}, 32'd0);
    chk("rst_flush",     {31'd0, flush},     32'd0);
    chk("rst_inflight",  {29'd0, inflight},  32'd0);
    chk("rst_resp_ready",{31'd0, resp_ready},32'd1);
    chk("rst_pc",        req_pc,             32'h8000_0000);

    // Release reset; still IDLE until the next edge.
    reset = 1'b1; #1;
    chk("idle_no_req", {31'd0, req_valid}, 32'd0);

    // Back-to-back issue, responses two cycles after each request.
    tick; req_ready = 1'b1; #1;
    chk("c0_valid", {31'd0, req_valid}, 32'd1);
    chk("c0_pc",    req_pc,             32'h8000_0000);
    chk("c0_size",  {29'd0, req_size},  32'd4);
    tick; #1;
    chk("c1_valid", {31'd0, req_valid}, 32'd1);
    chk("c1_pc",    req_pc,             32'h8000_0010);
    chk("c1_size",  {29'd0, req_size},  32'd4);
    chk("c1_infl",  {29'd0, inflight},  32'd1);
    tick; resp_valid = 1'b1; #1;
    chk("c2_max_infl", {29'd0, inflight},  32'd2);
    chk("c2_no_req",   {31'd0, req_valid}, 32'd0);
    chk("c2_enq",      {31'd0, enq_valid}, 32'd1);
    tick; req_ready = 1'b0; #1;
    chk("c3_enq",   {31'd0, enq_valid}, 32'd1);
    chk("c3_infl",  {29'd0, inflight},  32'd1);
    chk("c3_valid", {31'd0, req_valid}, 32'd1);
    tick; resp_valid = 1'b0; #1;
    chk("c4_infl",  {29'd0, inflight},  32'd0);

    // Ready held low for five cycles: request must stay stable.
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, req_valid}, 32'd1);
      chk("stall_pc",    req_pc,             32'h8000_0020);
      chk("stall_size",  {29'd0, req_size},  32'd4);
      tick; #1;
    end
    req_ready = 1'b1; #1;
    chk("stall_fire_valid", {31'd0, req_valid}, 32'd1);
    tick; req_ready = 1'b0; resp_valid = 1'b1; #1;
    chk("stall_single_fire", {29'd0, inflight}, 32'd1);
    chk("stall_next_pc",     req_pc,            32'h8000_0030);
    chk("stall_resp_enq",    {31'd0, enq_valid},32'd1);

    // Full buffer blocks requests; one free slot allows exactly one.
    tick; resp_valid = 1'b0; buf_count = 4'd6; req_ready = 1'b1; #1;
    chk("full_infl",   {29'd0, inflight},  32'd0);
    chk("full_no_req", {31'd0, req_valid}, 32'd0);
    tick; #1;
    chk("full_no_req2", {31'd0, req_valid}, 32'd0);
    tick; #1;
    chk("full_no_req3", {31'd0, req_valid}, 32'd0);
    tick; buf_count = 4'd5; #1;
    chk("one_slot_req", {31'd0, req_valid}, 32'd1);
    chk("one_slot_pc",  req_pc,             32'h8000_0030);
    tick; #1;
    chk("one_slot_blocked", {31'd0, req_valid}, 32'd0);
    chk("one_slot_infl",    {29'd0, inflight},  32'd1);
    tick; #1;
    chk("one_slot_blocked2", {31'd0, req_valid}, 32'd0);
    tick; req_ready = 1'b0; resp_valid = 1'b1; #1;
    chk("one_slot_enq", {31'd0, enq_valid}, 32'd1);

    // Two in flight, then redirect to 0x8000_000A (low bits ignored).
    tick; resp_valid = 1'b0; buf_count = 4'd0; req_ready = 1'b1; #1;
    chk("pre_redir_pc", req_pc, 32'h8000_0040);
    tick; #1;
    chk("pre_redir_pc2", req_pc, 32'h8000_0050);
    tick; redir_valid = 1'b1; redir_target = 32'h8000_000A; #1;
    chk("redir_flush", {31'd0, flush},     32'd1);
    chk("redir_noreq", {31'd0, req_valid}, 32'd0);
    chk("redir_infl",  {29'd0, inflight},  32'd2);
    tick; redir_valid = 1'b0; resp_valid = 1'b1; #1;
    chk("drain_pc",     req_pc,             32'h8000_0008);
    chk("drain_drop1",  {31'd0, enq_valid}, 32'd0);
    chk("drain_noreq1", {31'd0, req_valid}, 32'd0);
    chk("drain_flush0", {31'd0, flush},     32'd0);
    tick; #1;
    chk("drain_drop2",  {31'd0, enq_valid}, 32'd0);
    chk("drain_noreq2", {31'd0, req_valid}, 32'd0);
    chk("drain_infl",   {29'd0, inflight},  32'd1);
    tick; resp_valid = 1'b0; #1;
    chk("post_drain_valid", {31'd0, req_valid}, 32'd1);
    chk("post_drain_pc",    req_pc,             32'h8000_0008);
    chk("post_drain_size",  {29'd0, req_size},  32'd2);

    // Redirect coinciding with the only outstanding response: no DRAIN.
    tick; redir_valid = 1'b1; redir_target = 32'h8000_0104; resp_valid = 1'b1; #1;
    chk("redir_resp_infl",  {29'd0, inflight},  32'd1);
    chk("redir_resp_drop",  {31'd0, enq_valid}, 32'd0);
    chk("redir_resp_flush", {31'd0, flush},     32'd1);
    chk("redir_resp_noreq", {31'd0, req_valid}, 32'd0);
    tick; redir_valid = 1'b0; resp_valid = 1'b0; req_ready = 1'b0; #1;
    chk("no_drain_valid", {31'd0, req_valid}, 32'd1);
    chk("no_drain_pc",    req_pc,             32'h8000_0104);
    chk("no_drain_size",  {29'd0, req_size},  32'd3);
    chk("no_drain_infl",  {29'd0, inflight},  32'd0);

    // Redirect to the last group of the address space, then wrap.
    redir_valid = 1'b1; redir_target = 32'hFFFF_FFF0; #1;
    chk("wrap_flush", {31'd0, flush}, 32'd1);
    tick; redir_valid = 1'b0; req_ready = 1'b1; #1;
    chk("wrap_valid", {31'd0, req_valid}, 32'd1);
    chk("wrap_pc0",   req_pc,             32'hFFFF_FFF0);
    chk("wrap_size",  {29'd0, req_size},  32'd4);
    tick; req_ready = 1'b0; #1;
    chk("wrap_pc1",   req_pc,             32'h0000_0000);
    chk("wrap_infl",  {29'd0, inflight},  32'd1);

    // Redirect into DRAIN, then a second redirect while draining.
    redir_valid = 1'b1; redir_target = 32'h0000_0040; #1;
    chk("dr2_flush", {31'd0, flush}, 32'd1);
    tick; redir_target = 32'h0000_0084; #1;
    chk("dr2_flush_again", {31'd0, flush},     32'd1);
    chk("dr2_noreq",       {31'd0, req_valid}, 32'd0);
    chk("dr2_pc",          req_pc,             32'h0000_0040);
    tick; redir_valid = 1'b0; #1;
    chk("dr2_still_drain", {31'd0, req_valid}, 32'd0);
    chk("dr2_pc2",         req_pc,             32'h0000_0084);
    resp_valid = 1'b1; #1;
    chk("dr2_drop", {31'd0, enq_valid}, 32'd0);
    tick; resp_valid = 1'b0; #1;
    chk("dr2_resume_valid", {31'd0, req_valid}, 32'd1);
    chk("dr2_resume_pc",    req_pc,             32'h0000_0084);
    chk("dr2_resume_size",  {29'd0, req_size},  32'd3);
    req_ready = 1'b1;

    // Mid-operation reset discards in-flight state; IDLE ignores redirects.
    tick; req_ready = 1'b0; reset = 1'b0; #1;
    chk("mid_rst_pre_infl", {29'd0, inflight}, 32'd1);
    tick; redir_valid = 1'b1; redir_target = 32'h0000_1234; #1;
    chk("mid_rst_infl",  {29'd0, inflight},  32'd0);
    chk("mid_rst_pc",    req_pc,             32'h8000_0000);
    chk("mid_rst_flush", {31'd0, flush},     32'd0);
    chk("mid_rst_noreq", {31'd0, req_valid}, 32'd0);
    reset = 1'b1; #1;
    chk("idle_ignore_flush", {31'd0, flush}, 32'd0);
    tick; redir_valid = 1'b0; #1;
    chk("restart_valid", {31'd0, req_valid}, 32'd1);
    chk("restart_pc",    req_pc,             32'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
